// File: rtl/mire_pkg.sv
// rtl/mire_pkg.sv - shared FSM state type and RGB565 colour-bar table for mire_fb_writer
package mire_pkg;

  typedef enum logic [1:0] {IDLE, WRITE, RELEASE} state_t;

  localparam int BAND_COUNT = 8;

  localparam logic [15:0] COLOUR_LUT [BAND_COUNT] = '{
    16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
    16'hF81F, 16'hF800, 16'h001F, 16'h0000
  };

  function automatic logic [15:0] colour_of(input logic [2:0] idx);
    return COLOUR_LUT[idx];
  endfunction

endpackage

// File: rtl/mire_pixel_gen.sv
// rtl/mire_pixel_gen.sv - x/y/band counters with registered byte address and RGB565 data of the pixel to write
module mire_pixel_gen #(
  parameter int          HDISP = 640,
  parameter int          VDISP = 480,
  parameter logic [31:0] BASE  = 32'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        advance,
  input  logic [2:0]  offset,
  output logic        last,
  output logic [31:0] adr,
  output logic [15:0] dat
);
  import mire_pkg::*;

  localparam int XW     = (HDISP > 1) ? $clog2(HDISP) : 1;
  localparam int YW     = (VDISP > 1) ? $clog2(VDISP) : 1;
  localparam int BAND_W = HDISP / BAND_COUNT;
  localparam int BW     = (BAND_W > 1) ? $clog2(BAND_W) : 1;

  localparam logic [XW-1:0] X_LAST = XW'(HDISP - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(VDISP - 1);
  localparam logic [BW-1:0] B_LAST = BW'(BAND_W - 1);

  logic [XW-1:0] x, x_n;
  logic [YW-1:0] y, y_n;
  logic [BW-1:0] bcnt, bcnt_n;
  logic [2:0]    band, band_n;
  logic [2:0]    cidx;
  logic [31:0]   adr_n;

  assign last = (x == X_LAST) && (y == Y_LAST);

  // Band index follows x through a per-band pixel counter instead of dividing x.
  always_comb begin
    x_n    = x;
    y_n    = y;
    bcnt_n = bcnt;
    band_n = band;
    if (clear) begin
      x_n    = '0;
      y_n    = '0;
      bcnt_n = '0;
      band_n = '0;
    end else if (advance) begin
      if (x == X_LAST) begin
        x_n    = '0;
        bcnt_n = '0;
        band_n = '0;
        y_n    = (y == Y_LAST) ? '0 : y + 1'b1;
      end else begin
        x_n = x + 1'b1;
        if (bcnt == B_LAST) begin
          bcnt_n = '0;
          band_n = band + 1'b1;
        end else begin
          bcnt_n = bcnt + 1'b1;
        end
      end
    end
  end

  assign adr_n = BASE + ((32'(HDISP) * 32'(y_n) + 32'(x_n)) << 1);
  assign cidx  = band_n + offset;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x    <= '0;
      y    <= '0;
      bcnt <= '0;
      band <= '0;
      adr  <= '0;
      dat  <= '0;
    end else if (clear || advance) begin
      x    <= x_n;
      y    <= y_n;
      bcnt <= bcnt_n;
      band <= band_n;
      adr  <= adr_n;
      dat  <= colour_of(cidx);
    end
  end

endmodule

// File: rtl/mire_fb_writer.sv
// rtl/mire_fb_writer.sv - Wishbone master filling the SDRAM framebuffer with RGB565 colour bars
// Define MIRE_ANIM_EN to scroll the bars by one band on every completed frame.
module mire_fb_writer #(
  parameter int          HDISP = 640,
  parameter int          VDISP = 480,
  parameter logic [31:0] BASE  = 32'd0,
  parameter int          BURST = 64,
  parameter int          GAP   = 4
) (
  input  logic        CLK,
  input  logic        NRST,
  input  logic        start,
  input  logic        cont,
  output logic        busy,
  output logic        frame_done,
  output logic [31:0] wb_adr,
  output logic [15:0] wb_dat_ms,
  output logic [1:0]  wb_sel,
  output logic        wb_we,
  output logic        wb_cyc,
  output logic        wb_stb,
  output logic [2:0]  wb_cti,
  output logic [1:0]  wb_bte,
  input  logic        wb_ack
);
  import mire_pkg::*;

  localparam int BCW = $clog2(BURST) + 1;
  localparam int GCW = $clog2(GAP) + 1;
  localparam logic [BCW-1:0] BURST_LAST = BCW'(BURST - 1);
  localparam logic [GCW-1:0] GAP_LAST   = GCW'(GAP - 1);

  state_t         state, state_n;
  logic [BCW-1:0] burst_cnt;
  logic [GCW-1:0] gap_cnt;
  logic [2:0]     offset_n;
  logic           last, clear, advance;

  assign wb_sel = 2'b11;
  assign wb_we  = 1'b1;
  assign wb_cti = 3'd0;
  assign wb_bte = 2'd0;

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) state <= IDLE;
    else       state <= state_n;
  end

  // End of frame is checked before the burst limit so the last ack never releases the bus.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = WRITE;
      WRITE:   if (wb_ack) begin
                 if (last)                         state_n = cont ? WRITE : IDLE;
                 else if (burst_cnt == BURST_LAST) state_n = RELEASE;
               end
      RELEASE: if (gap_cnt == GAP_LAST) state_n = WRITE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    wb_cyc     = (state == WRITE);
    wb_stb     = (state == WRITE);
    busy       = (state != IDLE);
    advance    = (state == WRITE) && wb_ack;
    frame_done = (state == WRITE) && wb_ack && last;
    clear      = (state == IDLE) && start;
  end

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      burst_cnt <= '0;
      gap_cnt   <= '0;
    end else begin
      if (state != WRITE || (wb_ack && (last || burst_cnt == BURST_LAST)))
        burst_cnt <= '0;
      else if (wb_ack)
        burst_cnt <= burst_cnt + 1'b1;
      gap_cnt <= (state == RELEASE) ? gap_cnt + 1'b1 : '0;
    end
  end

`ifdef MIRE_ANIM_EN
  logic [2:0] offset;

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) offset <= '0;
    else       offset <= offset_n;
  end

  assign offset_n = frame_done ? offset + 3'd1 : offset;
`else
  assign offset_n = 3'd0;
`endif

  mire_pixel_gen #(
    .HDISP (HDISP),
    .VDISP (VDISP),
    .BASE  (BASE)
  ) u_pixel_gen (
    .clk     (CLK),
    .rst_n   (NRST),
    .clear   (clear),
    .advance (advance),
    .offset  (offset_n),
    .last    (last),
    .adr     (wb_adr),
    .dat     (wb_dat_ms)
  );

endmodule
